// File: rtl/branch_predict_resolve_unit_if.sv
// Signal bundle between the pipeline (fetch/execute) and the branch predict/resolve unit.
// The pipeline holds the master side and the unit holds the slave side.
interface branch_predict_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) ();
  logic [XLEN-1:0]  fetch_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  logic             ex_valid;
  logic             ex_b_type;
  logic             ex_jal;
  logic             ex_jalr;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             flush;

  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             res_valid;
  logic [XLEN-1:0]  res_link;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output fetch_pc, ex_valid, ex_b_type, ex_jal, ex_jalr, ex_funct3,
           ex_rs1, ex_rs2, ex_imm, ex_pc, ex_pred_taken, ex_pred_target, flush,
    input  pred_taken, pred_target, redirect_valid, redirect_pc,
           res_valid, res_link, branch_cnt, mispred_cnt
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_b_type, ex_jal, ex_jalr, ex_funct3,
           ex_rs1, ex_rs2, ex_imm, ex_pc, ex_pred_taken, ex_pred_target, flush,
    output pred_taken, pred_target, redirect_valid, redirect_pc,
           res_valid, res_link, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_resolve_unit.sv
// Fetch-stage BTB/BHT prediction plus a registered execute-stage resolution that
// detects mispredicts, redirects fetch and trains the predictor tables.
module branch_predict_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input logic                          clk,
  input logic                          rst,
  branch_predict_resolve_unit_if.slave bus
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX-1:0]   idx_t;

  typedef struct packed {
    logic  valid;
    logic  redirect;
    word_t redirect_pc;
    word_t link;
    word_t pc;
    logic  taken;
    word_t target;
    logic  is_branch;
    logic  is_jump;
  } res_t;

  res_t               res_q, res_d;
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [BTB_ENTRIES-1:0] btb_jump_q, btb_jump_d;
  logic [1:0]             bht_q [BTB_ENTRIES];
  logic [1:0]             bht_d [BTB_ENTRIES];
  tag_t                   btb_tag_q [BTB_ENTRIES];
  tag_t                   btb_tag_d [BTB_ENTRIES];
  word_t                  btb_target_q [BTB_ENTRIES];
  word_t                  btb_target_d [BTB_ENTRIES];

  // ---------------------------------------------------------------- execute
  logic cond_met;
  always_comb begin
    // NOTE: the default arm assigns cond_met on every path; a missing arm would infer a latch.
    case (bus.ex_funct3)
      3'b000:  cond_met = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  cond_met = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  cond_met = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      3'b101:  cond_met = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  cond_met = (bus.ex_rs1 <  bus.ex_rs2);
      3'b111:  cond_met = (bus.ex_rs1 >= bus.ex_rs2);
      default: cond_met = 1'b0;
    endcase
  end

  logic  ex_is_jump, ex_is_branch, ex_taken, ex_mispredict, capture;
  word_t jalr_sum, ex_target, ex_next_pc;
  always_comb begin
    ex_is_jump    = bus.ex_jal | bus.ex_jalr;
    ex_is_branch  = bus.ex_b_type & ~ex_is_jump;
    jalr_sum      = bus.ex_rs1 + bus.ex_imm;
    ex_target     = bus.ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : bus.ex_pc + bus.ex_imm;
    ex_taken      = ex_is_jump | (ex_is_branch & cond_met);
    ex_next_pc    = ex_taken ? ex_target : bus.ex_pc + INSN_BYTES;
    ex_mispredict = (bus.ex_pred_taken != ex_taken) |
                    (ex_taken & (bus.ex_pred_target != ex_target));
    // An outgoing redirect kills the younger instruction now in execute.
    capture       = bus.ex_valid & (bus.ex_b_type | ex_is_jump) & ~bus.flush & ~res_q.redirect;
  end

  always_comb begin
    res_d = '0;
    if (capture) begin
      res_d.valid       = 1'b1;
      res_d.redirect    = ex_mispredict;
      res_d.redirect_pc = ex_mispredict ? ex_next_pc : '0;
      res_d.link        = ex_is_jump ? bus.ex_pc + INSN_BYTES : '0;
      res_d.pc          = bus.ex_pc;
      res_d.taken       = ex_taken;
      res_d.target      = ex_target;
      res_d.is_branch   = ex_is_branch;
      res_d.is_jump     = ex_is_jump;
    end
    branch_cnt_d  = branch_cnt_q + CNT_W'(res_q.valid);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(res_q.redirect);
  end

  // --------------------------------------------------------------- training
  idx_t train_idx;
  tag_t train_tag;
  always_comb begin
    train_idx    = res_q.pc[IDX+1:2];
    train_tag    = res_q.pc[XLEN-1:IDX+2];
    btb_valid_d  = btb_valid_q;
    btb_jump_d   = btb_jump_q;
    bht_d        = bht_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (res_q.valid) begin
      if (res_q.is_branch) begin
        if (res_q.taken && bht_q[train_idx] != 2'b11) begin
          bht_d[train_idx] = bht_q[train_idx] + 2'd1;
        end else if (!res_q.taken && bht_q[train_idx] != 2'b00) begin
          bht_d[train_idx] = bht_q[train_idx] - 2'd1;
        end
      end
      // Only taken outcomes allocate; jumps are always taken.
      if (res_q.taken) begin
        btb_valid_d[train_idx]  = 1'b1;
        btb_jump_d[train_idx]   = res_q.is_jump;
        btb_tag_d[train_idx]    = train_tag;
        btb_target_d[train_idx] = res_q.target;
      end
    end
  end

  // NOTE: clocked blocks use <= only, so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      btb_valid_q   <= '0;
      btb_jump_q    <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      res_q         <= res_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      btb_valid_q   <= btb_valid_d;
      btb_jump_q    <= btb_jump_d;
      bht_q         <= bht_d;
    end
  end

  // NOTE: tag/target storage is deliberately not reset; btb_valid_q qualifies every read.
  always_ff @(posedge clk) begin
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
  end

  // ----------------------------------------------------------------- lookup
  idx_t fetch_idx;
  tag_t fetch_tag;
  logic fetch_hit;
  always_comb begin
    fetch_idx = bus.fetch_pc[IDX+1:2];
    fetch_tag = bus.fetch_pc[XLEN-1:IDX+2];
    fetch_hit = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
  end

  assign bus.pred_taken     = fetch_hit & (btb_jump_q[fetch_idx] | bht_q[fetch_idx][1]);
  assign bus.pred_target    = fetch_hit ? btb_target_q[fetch_idx] : bus.fetch_pc + INSN_BYTES;

  assign bus.res_valid      = res_q.valid;
  assign bus.redirect_valid = res_q.redirect;
  assign bus.redirect_pc    = res_q.redirect_pc;
  assign bus.res_link       = res_q.link;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc[1:0], res_q.pc[1:0]};
endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Randomised and directed bench for branch_predict_resolve_unit against a
// table-level reference model of prediction, resolution and training.
module tb_branch_predict_resolve_unit;
  localparam int XLEN  = 32;
  localparam int N     = 16;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predict_resolve_unit #(.XLEN(XLEN), .BTB_ENTRIES(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  typedef struct packed {
    logic        valid;
    logic        redirect;
    logic        taken;
    logic        is_branch;
    logic [31:0] redirect_pc;
    logic [31:0] link;
    logic [31:0] pc;
    logic [31:0] target;
  } mres_t;

  bit          m_valid [N];
  bit          m_jump  [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_bht   [N];
  mres_t       m_res;
  int unsigned m_bcnt, m_mcnt;

  function automatic logic [32:0] model_predict(input logic [31:0] pc);
    int          idx;
    bit          hit;
    logic [31:0] tgt;
    idx = int'((pc / 4) % N);
    hit = m_valid[idx] && (m_tag[idx] == pc / (4 * N));
    tgt = hit ? m_tgt[idx] : pc + 32'd4;
    return {hit && (m_jump[idx] || m_bht[idx] >= 2), tgt};
  endfunction

  function automatic bit model_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs driven this cycle.
  task automatic model_clock();
    int          idx;
    bit          jump, taken, misp;
    logic [31:0] tgt, nxt_pc;
    mres_t       nxt;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0;
        m_jump[i]  = 0;
        m_bht[i]   = 1;
      end
      m_res  = '0;
      m_bcnt = 0;
      m_mcnt = 0;
      return;
    end
    if (m_res.valid) begin
      idx = int'((m_res.pc / 4) % N);
      if (m_res.is_branch)
        m_bht[idx] = m_res.taken ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                                 : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
      if (m_res.taken) begin
        m_valid[idx] = 1;
        m_jump[idx]  = !m_res.is_branch;
        m_tag[idx]   = m_res.pc / (4 * N);
        m_tgt[idx]   = m_res.target;
      end
      m_bcnt++;
    end
    if (m_res.redirect) m_mcnt++;
    nxt = '0;
    if (bus.ex_valid && (bus.ex_b_type || bus.ex_jal || bus.ex_jalr) && !bus.flush && !m_res.redirect) begin
      jump   = bus.ex_jal || bus.ex_jalr;
      taken  = jump || model_cond(bus.ex_funct3, bus.ex_rs1, bus.ex_rs2);
      tgt    = bus.ex_jalr ? ((bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE) : bus.ex_pc + bus.ex_imm;
      nxt_pc = taken ? tgt : bus.ex_pc + 32'd4;
      misp   = (bus.ex_pred_taken != taken) || (taken && bus.ex_pred_target != tgt);
      nxt.valid       = 1;
      nxt.redirect    = misp;
      nxt.redirect_pc = misp ? nxt_pc : 32'd0;
      nxt.link        = jump ? bus.ex_pc + 32'd4 : 32'd0;
      nxt.pc          = bus.ex_pc;
      nxt.taken       = taken;
      nxt.is_branch   = !jump;
      nxt.target      = tgt;
    end
    m_res = nxt;
  endtask

  // ------------------------------------------------------------- stimulus
  task automatic idle();
    rst                = 1'b0;
    bus.flush          = 1'b0;
    bus.ex_valid       = 1'b0;
    bus.ex_b_type      = 1'b0;
    bus.ex_jal         = 1'b0;
    bus.ex_jalr        = 1'b0;
    bus.ex_funct3      = 3'd0;
    bus.ex_rs1         = '0;
    bus.ex_rs2         = '0;
    bus.ex_imm         = '0;
    bus.ex_pc          = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;
  endtask

  task automatic set_ex(input bit b, input bit j, input bit jr, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input bit pt, input logic [31:0] ptg);
    bus.ex_valid       = 1'b1;
    bus.ex_b_type      = b;
    bus.ex_jal         = j;
    bus.ex_jalr        = jr;
    bus.ex_funct3      = f3;
    bus.ex_rs1         = rs1;
    bus.ex_rs2         = rs2;
    bus.ex_imm         = imm;
    bus.ex_pc          = pc;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptg;
  endtask

  // One clock: lookup checked mid-cycle, registered outputs checked at the next falling edge.
  task automatic step();
    logic [32:0] p;
    #1;
    p = model_predict(bus.fetch_pc);
    check("pred_taken", {31'd0, bus.pred_taken}, {31'd0, p[32]});
    check("pred_target", bus.pred_target, p[31:0]);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check("res_valid", {31'd0, bus.res_valid}, {31'd0, m_res.valid});
    check("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_res.redirect});
    check("redirect_pc", bus.redirect_pc, m_res.redirect_pc);
    check("res_link", bus.res_link, m_res.link);
    check("branch_cnt", bus.branch_cnt, m_bcnt);
    check("mispred_cnt", bus.mispred_cnt, m_mcnt);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input bit exp_taken, input logic [31:0] exp_tgt);
    bus.fetch_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, bus.pred_taken}, {31'd0, exp_taken});
    check({tag, "_target"}, bus.pred_target, exp_tgt);
  endtask

  initial begin
    logic [31:0] bc0, r, pc, rs1;
    logic [32:0] p;
    int          kind;

    idle();
    bus.fetch_pc = '0;
    rst = 1'b1;
    @(negedge clk);
    step();
    check("rst_branch_cnt", bus.branch_cnt, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    idle();

    // Cold BEQ taken, predicted not-taken.
    lookup("t1_cold", 32'h100, 1'b0, 32'h104);
    set_ex(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 0, 32'h0);
    step();
    check("t1_redirect", {31'd0, bus.redirect_valid}, 32'd1);
    check("t1_redirect_pc", bus.redirect_pc, 32'h120);
    idle();
    step();
    check("t1_mispred_cnt", bus.mispred_cnt, 32'd1);

    // Same BEQ correctly predicted; BHT reaches 11.
    lookup("t2_pre", 32'h100, 1'b1, 32'h120);
    set_ex(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 1, 32'h120);
    step();
    check("t2_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    idle();
    step();
    lookup("t2_post", 32'h100, 1'b1, 32'h120);
    // A single not-taken outcome leaves a strongly-taken counter still predicting taken.
    set_ex(1, 0, 0, 3'b000, 32'd5, 32'd6, 32'h20, 32'h100, 1, 32'h120);
    step();
    check("t2_nt_redirect_pc", bus.redirect_pc, 32'h104);
    idle();
    step();
    lookup("t2_hyst", 32'h100, 1'b1, 32'h120);

    // Signed versus unsigned less-than.
    set_ex(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 0, 32'h0);
    step();
    check("t3_blt_redirect_pc", bus.redirect_pc, 32'h340);
    idle();
    step();
    set_ex(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 1, 32'h340);
    step();
    check("t3_bltu_redirect_pc", bus.redirect_pc, 32'h304);
    idle();
    step();
    // Two correctly predicted not-taken branches on index 0 drive its counter low.
    set_ex(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 0, 32'h0);
    step();
    step();
    check("t3_nt_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    idle();
    step();

    // JALR clears bit 0 and provides the link; a jump entry predicts taken whatever the BHT says.
    set_ex(0, 0, 1, 3'b000, 32'h1003, 32'd0, 32'h0, 32'h200, 0, 32'h0);
    step();
    check("t4_redirect_pc", bus.redirect_pc, 32'h1002);
    check("t4_link", bus.res_link, 32'h204);
    idle();
    step();
    lookup("t4_jump", 32'h200, 1'b1, 32'h1002);

    // Redirect squashes the next instruction; flush blocks capture.
    bc0 = bus.branch_cnt;
    set_ex(1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h10, 32'h500, 0, 32'h0);
    step();
    check("t5_redirect", {31'd0, bus.redirect_valid}, 32'd1);
    set_ex(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h8, 32'h600, 0, 32'h0);
    step();
    check("t5_squash", {31'd0, bus.res_valid}, 32'd0);
    idle();
    step();
    check("t5_branch_cnt", bus.branch_cnt, bc0 + 32'd1);
    set_ex(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h8, 32'h600, 0, 32'h0);
    bus.flush = 1'b1;
    step();
    check("t5_flush", {31'd0, bus.res_valid}, 32'd0);
    idle();
    step();

    // Aliased PCs share index 0 with different tags.
    set_ex(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h100, 32'h40, 0, 32'h0);
    step();
    idle();
    step();
    lookup("t6_hit", 32'h40, 1'b1, 32'h140);
    lookup("t6_alias", 32'h80, 1'b0, 32'h84);
    // Reset while a mispredict is pending.
    set_ex(1, 0, 0, 3'b000, 32'd1, 32'd1, 32'h8, 32'h80, 0, 32'h0);
    step();
    check("t6_pending", {31'd0, bus.redirect_valid}, 32'd1);
    idle();
    rst = 1'b1;
    step();
    check("t6_rst_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    check("t6_rst_mispred_cnt", bus.mispred_cnt, 32'd0);
    idle();
    lookup("t6_rst_table", 32'h40, 1'b0, 32'h44);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      idle();
      rst       = ($urandom_range(0, 249) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      pc        = 32'($urandom_range(0, 255)) << 2;
      kind      = $urandom_range(0, 9);
      if ($urandom_range(0, 4) != 0) begin
        r   = $urandom;
        rs1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        set_ex(kind < 6, kind == 6 || kind == 7, kind == 8, 3'($urandom_range(0, 7)), rs1,
               $urandom_range(0, 1) ? rs1 : 32'($urandom_range(0, 3)),
               (kind == 8) ? {{20{r[11]}}, r[11:0]} : {{20{r[11]}}, r[11:1], 1'b0},
               pc, 0, 32'h0);
        p = model_predict(pc);
        if ($urandom_range(0, 1) != 0) begin
          bus.ex_pred_taken  = p[32];
          bus.ex_pred_target = p[31:0];
        end else begin
          bus.ex_pred_taken  = 1'($urandom_range(0, 1));
          bus.ex_pred_target = $urandom_range(0, 1) ? p[31:0] : $urandom;
        end
      end
      bus.fetch_pc = $urandom_range(0, 2) == 0 ? m_res.pc : 32'($urandom_range(0, 255)) << 2;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/branch_predict_resolve_unit.md
Name: branch_predict_resolve_unit

Overview:
- Parametrised successor to the combinational branch/jump target logic.
- Adds a direct-mapped BTB and a 2-bit BHT for fetch-stage prediction.
- Adds a registered resolution stage that compares the actual outcome against the prediction carried down the pipe, then issues a redirect and trains the predictor.
- Sits between execute (resolution) and fetch (lookup, redirect).

Parameters:
- XLEN, 32, datapath/PC width.
- BTB_ENTRIES, 16, BTB/BHT depth; power of two, ≥2; IDX=log2(BTB_ENTRIES).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fetch_pc  in  XLEN  PC being fetched (lookup).
- pred_taken  out  1  fetch prediction: taken.
- pred_target  out  XLEN  fetch prediction: target.
- ex_valid  in  1  execute-stage instruction valid.
- ex_b_type  in  1  conditional branch.
- ex_jal  in  1  JAL.
- ex_jalr  in  1  JALR.
- ex_funct3  in  3  branch condition.
- ex_rs1  in  XLEN  operand 1 / JALR base.
- ex_rs2  in  XLEN  operand 2.
- ex_imm  in  XLEN  sign-extended immediate (B/J/I, bit0 already 0 for B/J).
- ex_pc  in  XLEN  instruction PC.
- ex_pred_taken  in  1  prediction made at fetch.
- ex_pred_target  in  XLEN  predicted target made at fetch.
- flush  in  1  external squash of the execute stage.
- redirect_valid  out  1  mispredict; fetch must restart.
- redirect_pc  out  XLEN  correct next PC.
- res_valid  out  1  resolution stage holds a control-flow instruction.
- res_link  out  XLEN  return address (pc+4) for JAL/JALR, else 0.
- branch_cnt  out  CNT_W  resolved control-flow instructions.
- mispred_cnt  out  CNT_W  mispredicts.

Behaviour:
- Condition (combinational, execute): 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE. 010/011 are not taken.
- Target (modulo 2^XLEN):
  - JAL: ex_pc+ex_imm.
  - JALR: (ex_rs1+ex_imm) with bit0 cleared.
  - Branch: ex_pc+ex_imm.
- taken = JAL | JALR | (b_type & cond). next_pc = taken ? target : ex_pc+4.
- Capture into the resolution register occurs when ex_valid & (b_type|jal|jalr) & !flush & !redirect_valid. The self-kill squashes the younger instruction in the cycle a redirect is asserted. Otherwise res_valid ← 0.
- Latency: capture at edge N; res_valid, redirect_*, res_link are valid in cycle N+1 for exactly one cycle. All are registered outputs.
- Mispredict = (pred_taken_cap != taken) | (taken & pred_target_cap != target).
- redirect_valid = res_valid & mispredict. redirect_pc = next_pc (0 when not redirecting).
- Lookup:
  - idx = fetch_pc[IDX+1:2]; tag = fetch_pc[XLEN-1:IDX+2].
  - hit = valid[idx] & tag match.
  - pred_taken = hit & (is_jump[idx] | bht[idx][1]).
  - pred_target = hit ? btb_target[idx] : fetch_pc+4.
  - Purely combinational from table state.
- Training, at the edge ending a res_valid cycle, using the resolved PC's idx/tag:
  - Branch: BHT counter saturates up if taken, down if not (00..11). The BTB entry (tag, target, valid=1, is_jump=0) is written only if taken.
  - JAL/JALR: BTB entry is written with is_jump=1; BHT is unchanged.
  - Not-taken branch on a tag miss: counter still updates; no BTB write.
- Read/write same index in the same cycle: lookup returns the pre-update value.
- Perf counters increment on res_valid (branch_cnt) and redirect_valid (mispred_cnt). They wrap at 2^CNT_W.
- Reset (synchronous, rst=1 at edge):
  - All BTB valid=0; all BHT=01.
  - res_valid, redirect_valid, redirect_pc, res_link = 0; counters = 0.
  - Reset mid-operation discards any pending resolution with no redirect; reset dominates flush and capture.
- flush and ex_valid in the same cycle: nothing is captured, no training, counters unchanged.

Test Plan:
1. After reset, fetch_pc=0x100 → pred_taken=0, pred_target=0x104. BEQ at 0x100, rs1=rs2=5, imm=0x20, pred 0 → next cycle redirect_valid=1, redirect_pc=0x120, mispred_cnt=1, BHT[0]=10.
2. Repeat the same BEQ with pred_taken=1, pred_target=0x120 → redirect_valid=0, BHT→11. A subsequent lookup of 0x100 gives pred_taken=1, target 0x120.
3. Signedness: BLT with rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken, next_pc=pc+4.
4. JALR at 0x200, rs1=0x1003, imm=0 → target 0x1002, res_link=0x204, BTB is_jump set. Re-lookup of 0x200 → pred_taken=1 regardless of BHT.
5. Back-to-back: a mispredicted branch is followed next cycle by ex_valid JAL → the JAL is squashed (no res_valid, branch_cnt +1 only). Also, flush=1 with ex_valid → no capture.
6. Aliasing and reset: PCs 0x40 and 0x80 (BTB_ENTRIES=16) share an index with different tags → miss on the other tag. Assert rst during res_valid → no redirect, tables and counters are cleared.
